// File: rtl/dest_pkg.sv
package dest_pkg;

  localparam int unsigned NIB_DEF   = 4;
  localparam logic [2:0]  MASK_FULL = 3'b111;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // Position of the set bit in a one-hot select; only meaningful when one-hot.
  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dest_nibble_reg.sv
module dest_nibble_reg #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/dest_reg_bank.sv
module dest_reg_bank
  import dest_pkg::*;
#(
  parameter int unsigned NIB = NIB_DEF
) (
  input  logic             CLK1,
  input  logic             RST_N,
  input  logic             LDD,
  input  logic [NIB-1:0]   D,
  input  logic             S0,
  input  logic             S1,
  input  logic             S2,
  input  logic             ACK,
  output logic [NIB-1:0]   R0,
  output logic [NIB-1:0]   R1,
  output logic [NIB-1:0]   R2,
  output logic [3*NIB-1:0] WORD,
  output logic             VALID,
  output logic             SEL_ERR,
  output logic             OVR
);

  state_t     state;
  logic [2:0] mask;
  logic [2:0] sel;
  logic       sel_ok;
  logic       load_req;
  logic       load_acc;
  logic [2:0] wr_en;
  logic [2:0] mask_set;

  assign sel      = {S2, S1, S0};
  assign sel_ok   = $onehot(sel);
  assign load_req = LDD & sel_ok;
  // An ACK in FULL frees the bank on the same edge, so that load is taken.
  assign load_acc = load_req & ((state == FILL) | ACK);
  assign mask_set = mask | sel;

  always_comb begin
    wr_en = '0;
    if (load_acc) wr_en = 3'b001 << onehot_to_idx(sel);
  end

  always_ff @(posedge CLK1 or negedge RST_N) begin
    if (!RST_N) begin
      state   <= FILL;
      mask    <= '0;
      SEL_ERR <= 1'b0;
      OVR     <= 1'b0;
    end else begin
      SEL_ERR <= LDD & ~sel_ok;
      OVR     <= load_req & (state == FULL) & ~ACK;
      case (state)
        FILL: begin
          if (load_acc) begin
            mask <= mask_set;
            if (mask_set == MASK_FULL) state <= FULL;
          end
        end
        FULL: begin
          if (ACK) begin
            mask  <= load_acc ? sel : '0;
            state <= FILL;
          end
        end
        default: begin
          state <= FILL;
          mask  <= '0;
        end
      endcase
    end
  end

  dest_nibble_reg #(.W(NIB)) u_r0 (
    .clk(CLK1), .rst_n(RST_N), .en(wr_en[0]), .d(D), .q(R0)
  );
  dest_nibble_reg #(.W(NIB)) u_r1 (
    .clk(CLK1), .rst_n(RST_N), .en(wr_en[1]), .d(D), .q(R1)
  );
  dest_nibble_reg #(.W(NIB)) u_r2 (
    .clk(CLK1), .rst_n(RST_N), .en(wr_en[2]), .d(D), .q(R2)
  );

  assign WORD  = {R2, R1, R0};
  assign VALID = (state == FULL);

endmodule

// File: tb/tb_dest_reg_bank.sv
module tb_dest_reg_bank;

  logic        CLK1 = 1'b0;
  logic        RST_N;
  logic        LDD;
  logic [3:0]  D;
  logic        S0, S1, S2;
  logic        ACK;
  logic [3:0]  R0, R1, R2;
  logic [11:0] WORD;
  logic        VALID, SEL_ERR, OVR;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state.
  logic [3:0] mr [3];
  bit         ml [3];
  bit         mv, mse, mov;

  dest_reg_bank #(.NIB(4)) dut (
    .CLK1(CLK1), .RST_N(RST_N), .LDD(LDD), .D(D),
    .S0(S0), .S1(S1), .S2(S2), .ACK(ACK),
    .R0(R0), .R1(R1), .R2(R2), .WORD(WORD),
    .VALID(VALID), .SEL_ERR(SEL_ERR), .OVR(OVR)
  );

  always #5 CLK1 = ~CLK1;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mr[i] = '0;
      ml[i] = 1'b0;
    end
    mv  = 1'b0;
    mse = 1'b0;
    mov = 1'b0;
  endtask

  // Word-level view: a word is a set of three slots; it is complete once every slot
  // has been written since the last accept.
  task automatic model_step(input bit ldd, input logic [3:0] d, input logic [2:0] s, input bit ack);
    int  n;
    int  idx;
    bit  was_valid;
    n = 0;
    idx = 0;
    for (int i = 0; i < 3; i++) if (s[i]) begin n++; idx = i; end
    was_valid = mv;
    mse = ldd && (n != 1);
    mov = was_valid && !ack && ldd && (n == 1);
    if (was_valid && ack) begin
      mv = 1'b0;
      for (int i = 0; i < 3; i++) ml[i] = 1'b0;
    end
    if (ldd && n == 1 && (!was_valid || ack)) begin
      mr[idx] = d;
      ml[idx] = 1'b1;
      if (ml[0] && ml[1] && ml[2]) mv = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".R0"},     {8'h0, R0}, {8'h0, mr[0]});
    check({tag, ".R1"},     {8'h0, R1}, {8'h0, mr[1]});
    check({tag, ".R2"},     {8'h0, R2}, {8'h0, mr[2]});
    check({tag, ".WORD"},   WORD, {mr[2], mr[1], mr[0]});
    check({tag, ".VALID"},  {11'h0, VALID},   {11'h0, mv});
    check({tag, ".SEL_ERR"},{11'h0, SEL_ERR}, {11'h0, mse});
    check({tag, ".OVR"},    {11'h0, OVR},     {11'h0, mov});
  endtask

  task automatic cycle(input string tag, input bit ldd, input logic [3:0] d,
                       input logic [2:0] s, input bit ack);
    LDD = ldd; D = d; {S2, S1, S0} = s; ACK = ack;
    @(posedge CLK1);
    model_step(ldd, d, s, ack);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [2:0] rs;
    RST_N = 1'b0;
    LDD = 0; D = '0; S0 = 0; S1 = 0; S2 = 0; ACK = 0;
    model_reset();
    #12;
    check_all("reset");
    RST_N = 1'b1;

    // Fill in selector order S2, S0, S1.
    cycle("fill_s2", 1, 4'hA, 3'b100, 0);
    cycle("fill_s0", 1, 4'h3, 3'b001, 0);
    cycle("fill_s1", 1, 4'h5, 3'b010, 0);
    check("word_a53", WORD, 12'hA53);
    check("valid_a53", {11'h0, VALID}, 12'h1);

    // Load while pending is dropped.
    cycle("ovr", 1, 4'hF, 3'b001, 0);
    check("ovr_r0_held", {8'h0, R0}, 12'h3);
    check("ovr_pulse", {11'h0, OVR}, 12'h1);
    cycle("ovr_end", 0, 4'h0, 3'b000, 0);

    // Accept coinciding with first load of the next word.
    cycle("ack_load", 1, 4'h7, 3'b010, 1);
    check("ack_valid_low", {11'h0, VALID}, 12'h0);
    cycle("refill_s0", 1, 4'h1, 3'b001, 0);
    cycle("refill_s2", 1, 4'h2, 3'b100, 0);
    check("refill_valid", {11'h0, VALID}, 12'h1);
    cycle("ack_only", 0, 4'h0, 3'b000, 1);

    // Malformed selects.
    cycle("selerr_multi", 1, 4'h9, 3'b011, 0);
    cycle("selerr_none", 1, 4'h9, 3'b000, 0);
    check("selerr_held", {11'h0, SEL_ERR}, 12'h1);
    cycle("selerr_end", 0, 4'h0, 3'b000, 0);

    // Overwrite before completion.
    cycle("ow_1", 1, 4'h1, 3'b001, 0);
    cycle("ow_2", 1, 4'h2, 3'b001, 0);
    cycle("ow_3", 1, 4'h4, 3'b010, 0);
    check("ow_not_valid", {11'h0, VALID}, 12'h0);
    cycle("ow_4", 1, 4'h8, 3'b100, 0);
    check("ow_valid", {11'h0, VALID}, 12'h1);
    check("ow_r0", {8'h0, R0}, 12'h2);

    // Async reset between edges while FULL.
    RST_N = 1'b0;
    #2;
    model_reset();
    check_all("async_rst");
    check("async_word", WORD, 12'h000);
    @(negedge CLK1);
    RST_N = 1'b1;
    cycle("rb_s2", 1, 4'hC, 3'b100, 0);
    cycle("rb_s0", 1, 4'hD, 3'b001, 0);
    cycle("rb_s1", 1, 4'hE, 3'b010, 0);
    check("rb_word", WORD, 12'hCED);

    // Randomized traffic, mostly well-formed selects.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) rs = 3'($urandom_range(0, 7));
      else                           rs = 3'b001 << $urandom_range(0, 2);
      cycle("rand", ($urandom_range(0, 3) != 0), 4'($urandom), rs,
            ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
